// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one instruction port and one data port share a
// single RAM. Data has priority, but a bounded starvation counter guarantees fetch progress.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        busy,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IREQ, DREQ} state_t;

  state_t           state;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_store;
  logic             lat_wen;
  logic [CNT_W-1:0] starve_cnt;

  logic starved;
  logic xfer_end;

  // Instruction side wins only once data has taken STARVE_LIMIT grants in a row.
  assign starved  = iREN && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign busy     = (state != IDLE);
  assign xfer_end = busy && ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_wen    <= 1'b0;
      starve_cnt <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((dREN || dWEN) && !starved) begin
            state     <= DREQ;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wen   <= dWEN;
            if (!iREN)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (iREN) begin
            state      <= IREQ;
            lat_addr   <= iaddr;
            lat_store  <= '0;
            lat_wen    <= 1'b0;
            starve_cnt <= '0;
          end
        end
        IREQ, DREQ: begin
          if (xfer_end) begin
            state <= IDLE;
            if (ramstate == RAM_ERROR)
              bus_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side is driven purely from latched transaction state.
  assign ramREN   = busy && !lat_wen;
  assign ramWEN   = busy && lat_wen;
  assign ramaddr  = busy ? lat_addr  : '0;
  assign ramstore = busy ? lat_store : '0;

  // Completion handshake toward the owner; ERROR completes with zero data.
  assign iwait = !((state == IREQ) && xfer_end);
  assign dwait = !((state == DREQ) && xfer_end);
  assign iload = ((state == IREQ) && (ramstate == RAM_ACCESS)) ? ramload : '0;
  assign dload = ((state == DREQ) && (ramstate == RAM_ACCESS)) ? ramload : '0;

endmodule
